// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl
// Drives one pe_8x8_cluster through a full tile. A tile clears the array,
// streams DEPTH activation/weight elements per row with a one-cycle-per-row
// skew, raises sticky per-row done flags, waits for the array's final done
// and pulses res_valid. A timeout while waiting sets a sticky err.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   en                   global enable; low freezes all feed/wait progress
//   start                begin a tile (accepted in IDLE with en=1 only)
//   busy                 high from start acceptance until DONE exit
//   res_valid            one-cycle pulse, array results are final
//   err                  sticky timeout flag
//   rd_en, rd_idx        per-bank read strobe and element index
//   act_rdata, wgt_rdata per-bank read data
//   arr_clr, arr_en      array clear and enable
//   activations, weights registered lane data, row r at [r*DW +: DW]
//   row_done             sticky per-row done to the array
//   array_done           array's last output_done bit
//   dbg_state            current FSM state for observation
//
// Bank handshake: rd_en[r] is a single-cycle request with rd_idx valid in
// the same cycle; the bank has no back-pressure and returns act/wgt_rdata
// exactly one cycle later. Only that cycle's data is meaningful.
module systolic_feed_ctrl #(
    parameter int ROWS  = 8,
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int IW    = 2,
    parameter int TMO   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    output logic               busy,
    output logic               res_valid,
    output logic               err,
    output logic [ROWS-1:0]    rd_en,
    output logic [ROWS*IW-1:0] rd_idx,
    input  logic [ROWS*DW-1:0] act_rdata,
    input  logic [ROWS*DW-1:0] wgt_rdata,
    output logic               arr_clr,
    output logic               arr_en,
    output logic [ROWS*DW-1:0] activations,
    output logic [ROWS*DW-1:0] weights,
    output logic [ROWS-1:0]    row_done,
    input  logic               array_done,
    output logic [2:0]         dbg_state
);

    localparam int FEED_LAST = ROWS + DEPTH + 1;
    localparam int CNT_MAX   = (FEED_LAST > TMO) ? FEED_LAST : TMO;
    localparam int CW        = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;       // feed cycle t, reused as wait counter
    logic [ROWS-1:0]           pend;      // read issued last cycle, data on rdata now
    logic [ROWS-1:0]           s1_valid;  // stage-1 holds data not yet on the lane
    logic [ROWS-1:0][DW-1:0]   s1_act;
    logic [ROWS-1:0][DW-1:0]   s1_wgt;
    logic [ROWS-1:0][DW-1:0]   act_lane;
    logic [ROWS-1:0][DW-1:0]   wgt_lane;

    assign activations = act_lane;
    assign weights     = wgt_lane;
    assign arr_en      = en & busy;
    assign dbg_state   = state;

    // Row r reads element k = t - r; rows outside 0 <= k < DEPTH stay quiet.
    always_comb begin
        rd_en  = '0;
        rd_idx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (state == S_FEED && en && int'(cnt) >= r && int'(cnt) - r < DEPTH) begin
                rd_en[r]           = 1'b1;
                rd_idx[r*IW +: IW] = IW'(int'(cnt) - r);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            arr_clr   <= 1'b0;
            row_done  <= '0;
            cnt       <= '0;
            pend      <= '0;
            s1_valid  <= '0;
            s1_act    <= '0;
            s1_wgt    <= '0;
            act_lane  <= '0;
            wgt_lane  <= '0;
        end else begin
            res_valid <= 1'b0;
            arr_clr   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && en) begin
                        state   <= S_CLEAR;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        arr_clr <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt      <= '0;
                    pend     <= '0;
                    s1_valid <= '0;
                    state    <= S_FEED;
                end
                S_FEED: begin
                    // Reads only happen with en high, so pend marks exactly
                    // the cycles whose rdata must be kept.
                    pend <= rd_en;
                    for (int r = 0; r < ROWS; r++) begin
                        if (pend[r]) begin
                            s1_act[r] <= act_rdata[r*DW +: DW];
                            s1_wgt[r] <= wgt_rdata[r*DW +: DW];
                        end
                        if (en) begin
                            // Bypass stage-1 when data arrives on an enabled
                            // cycle; stage-1 only matters across a stall.
                            if (pend[r]) begin
                                act_lane[r] <= act_rdata[r*DW +: DW];
                                wgt_lane[r] <= wgt_rdata[r*DW +: DW];
                            end else if (s1_valid[r]) begin
                                act_lane[r] <= s1_act[r];
                                wgt_lane[r] <= s1_wgt[r];
                            end else begin
                                act_lane[r] <= '0;
                                wgt_lane[r] <= '0;
                            end
                            s1_valid[r] <= 1'b0;
                            if (int'(cnt) == r + DEPTH + 1)
                                row_done[r] <= 1'b1;
                        end else if (pend[r]) begin
                            s1_valid[r] <= 1'b1;
                        end
                    end
                    if (en) begin
                        if (int'(cnt) == FEED_LAST) begin
                            state <= S_WAIT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    act_lane <= '0;
                    wgt_lane <= '0;
                    // array_done takes priority over a coinciding timeout.
                    if (array_done) begin
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (en) begin
                        if (int'(cnt) == TMO - 1) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    row_done <= '0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Testbench for systolic_feed_ctrl: emulates the banked buffers, drives
// tiles under nominal, stalled, random-enable, timeout and reset scenarios,
// and compares every lane/strobe against an arithmetic model of the skew.
module tb_systolic_feed_ctrl;

    localparam int ROWS  = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int IW    = 2;
    localparam int TMO   = 10;
    localparam int FEED_LAST = ROWS + DEPTH + 1;

    logic               clk;
    logic               rst;
    logic               en;
    logic               start;
    logic               busy;
    logic               res_valid;
    logic               err;
    logic [ROWS-1:0]    rd_en;
    logic [ROWS*IW-1:0] rd_idx;
    logic [ROWS*DW-1:0] act_rdata;
    logic [ROWS*DW-1:0] wgt_rdata;
    logic               arr_clr;
    logic               arr_en;
    logic [ROWS*DW-1:0] activations;
    logic [ROWS*DW-1:0] weights;
    logic [ROWS-1:0]    row_done;
    logic               array_done;
    logic [2:0]         dbg_state;

    logic [DW-1:0] act_mem [ROWS][DEPTH];
    logic [DW-1:0] wgt_mem [ROWS][DEPTH];

    int n_vec;
    int n_err;
    int rv_cnt;
    int clr_cnt;

    systolic_feed_ctrl #(
        .ROWS(ROWS), .DEPTH(DEPTH), .DW(DW), .IW(IW), .TMO(TMO)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .busy(busy), .res_valid(res_valid), .err(err),
        .rd_en(rd_en), .rd_idx(rd_idx),
        .act_rdata(act_rdata), .wgt_rdata(wgt_rdata),
        .arr_clr(arr_clr), .arr_en(arr_en),
        .activations(activations), .weights(weights),
        .row_done(row_done), .array_done(array_done),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bank emulation: data for a read appears one cycle later; other cycles
    // carry garbage so unguarded captures show up.
    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (rd_en[r]) begin
                act_rdata[r*DW +: DW] <= act_mem[r][rd_idx[r*IW +: IW]];
                wgt_rdata[r*DW +: DW] <= wgt_mem[r][rd_idx[r*IW +: IW]];
            end else begin
                act_rdata[r*DW +: DW] <= DW'($urandom);
                wgt_rdata[r*DW +: DW] <= DW'($urandom);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (res_valid) rv_cnt++;
            if (arr_clr) clr_cnt++;
        end
    end

    // Reference: element k of row r sits on its lane at feed cycle 2+r+k,
    // where feed cycles count only enabled FEED cycles.
    function automatic logic [DW-1:0] exp_lane(input int r, input int t, input bit w);
        int k;
        k = t - 2 - r;
        if (k >= 0 && k < DEPTH) return w ? wgt_mem[r][k] : act_mem[r][k];
        return '0;
    endfunction

    task automatic fill_pattern();
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < DEPTH; k++) begin
                act_mem[r][k] = DW'(r * DEPTH + k + 1);
                wgt_mem[r][k] = DW'(1000 + r * DEPTH + k);
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < DEPTH; k++) begin
                act_mem[r][k] = DW'($urandom);
                wgt_mem[r][k] = DW'($urandom);
            end
    endtask

    // Drives one tile. stall_t/stall_len: en low for stall_len cycles at
    // feed cycle stall_t. done_after: enabled WAIT cycles before array_done
    // (-1 = never). abort_t: reset at that feed cycle (-1 = none).
    task automatic run_tile(input int stall_t, input int stall_len, input bit rand_en,
                            input int done_after, input int abort_t, input bit poke_start);
        int t, stalled, we, guard;
        bit en_v, success;
        logic [DW-1:0] ea, ew;
        bit exp_rd, exp_rdone;

        @(negedge clk); start = 1'b1; en = 1'b1; array_done = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0; #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_busy got=%b exp=1", busy); end
        n_vec++; if (arr_clr !== 1'b1) begin n_err++; $display("FAIL clear_arr_clr got=%b exp=1", arr_clr); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL clear_err got=%b exp=0", err); end
        n_vec++; if (rd_en !== '0) begin n_err++; $display("FAIL clear_rd_en got=%h exp=0", rd_en); end
        @(posedge clk);

        t = 0; stalled = 0; guard = 0;
        forever begin
            @(negedge clk);
            if (abort_t >= 0 && t == abort_t) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk); rst = 1'b0; #1;
                n_vec++;
                if ({busy, res_valid, err, arr_clr, arr_en, rd_en, row_done} !== '0 ||
                    activations !== '0 || weights !== '0 || dbg_state !== 3'd0) begin
                    n_err++;
                    $display("FAIL abort_reset busy=%b rv=%b err=%b clr=%b rd_en=%h rdone=%h act=%h wgt=%h st=%0d exp=all zero",
                             busy, res_valid, err, arr_clr, rd_en, row_done, activations, weights, dbg_state);
                end
                return;
            end
            if (rand_en) en_v = ($urandom_range(0, 3) != 0);
            else if (t == stall_t && stalled < stall_len) begin en_v = 1'b0; stalled++; end
            else en_v = 1'b1;
            en = en_v; #1;
            n_vec++; if (arr_clr !== 1'b0) begin n_err++; $display("FAIL feed_arr_clr t=%0d got=%b exp=0", t, arr_clr); end
            n_vec++; if (arr_en !== en_v) begin n_err++; $display("FAIL feed_arr_en t=%0d got=%b exp=%b", t, arr_en, en_v); end
            for (int r = 0; r < ROWS; r++) begin
                ea = exp_lane(r, t, 1'b0);
                ew = exp_lane(r, t, 1'b1);
                exp_rd = en_v && (t - r >= 0) && (t - r < DEPTH);
                exp_rdone = (t >= 2 + r + DEPTH);
                n_vec++;
                if (activations[r*DW +: DW] !== ea) begin
                    n_err++; $display("FAIL lane_act r=%0d t=%0d got=%0d exp=%0d", r, t, activations[r*DW +: DW], ea);
                end
                n_vec++;
                if (weights[r*DW +: DW] !== ew) begin
                    n_err++; $display("FAIL lane_wgt r=%0d t=%0d got=%0d exp=%0d", r, t, weights[r*DW +: DW], ew);
                end
                n_vec++;
                if (rd_en[r] !== exp_rd) begin
                    n_err++; $display("FAIL rd_en r=%0d t=%0d en=%b got=%b exp=%b", r, t, en_v, rd_en[r], exp_rd);
                end
                if (exp_rd) begin
                    n_vec++;
                    if (rd_idx[r*IW +: IW] !== IW'(t - r)) begin
                        n_err++; $display("FAIL rd_idx r=%0d t=%0d got=%0d exp=%0d", r, t, rd_idx[r*IW +: IW], t - r);
                    end
                end
                n_vec++;
                if (row_done[r] !== exp_rdone) begin
                    n_err++; $display("FAIL row_done r=%0d t=%0d got=%b exp=%b", r, t, row_done[r], exp_rdone);
                end
            end
            @(posedge clk);
            if (en_v) begin
                if (t == FEED_LAST) break;
                t++;
            end
            guard++;
            if (guard > 400) begin
                n_vec++; n_err++; $display("FAIL feed_bound t=%0d exceeded cycle budget", t);
                return;
            end
        end

        we = 0; guard = 0; success = 1'b0;
        forever begin
            @(negedge clk);
            en_v = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            en = en_v;
            array_done = (done_after >= 0 && we >= done_after);
            start = poke_start && (we == 2);
            #1;
            n_vec++;
            if (busy !== 1'b1 || res_valid !== 1'b0 || err !== 1'b0) begin
                n_err++; $display("FAIL wait_flags we=%0d busy=%b rv=%b err=%b exp=1,0,0", we, busy, res_valid, err);
            end
            n_vec++;
            if (activations !== '0 || weights !== '0 || rd_en !== '0) begin
                n_err++; $display("FAIL wait_lanes we=%0d act=%h wgt=%h rd_en=%h exp=0", we, activations, weights, rd_en);
            end
            n_vec++;
            if (row_done !== {ROWS{1'b1}}) begin
                n_err++; $display("FAIL wait_row_done we=%0d got=%h exp=%h", we, row_done, {ROWS{1'b1}});
            end
            @(posedge clk);
            if (array_done) begin success = 1'b1; break; end
            if (en_v) begin
                we++;
                if (we == TMO) break;
            end
            guard++;
            if (guard > 400) begin
                n_vec++; n_err++; $display("FAIL wait_bound we=%0d exceeded cycle budget", we);
                return;
            end
        end

        @(negedge clk); array_done = 1'b0; start = 1'b0; en = 1'b1; #1;
        n_vec++; if (res_valid !== success) begin n_err++; $display("FAIL done_res_valid got=%b exp=%b", res_valid, success); end
        n_vec++; if (err !== !success) begin n_err++; $display("FAIL done_err got=%b exp=%b", err, !success); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL done_busy got=%b exp=1", busy); end
        @(posedge clk);
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL idle_res_valid got=%b exp=0", res_valid); end
        n_vec++; if (row_done !== '0) begin n_err++; $display("FAIL idle_row_done got=%h exp=0", row_done); end
        n_vec++; if (err !== !success) begin n_err++; $display("FAIL idle_err_sticky got=%b exp=%b", err, !success); end
        @(posedge clk);
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0 || arr_clr !== 1'b0) begin
            n_err++; $display("FAIL idle_hold busy=%b arr_clr=%b exp=0,0", busy, arr_clr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; start = 1'b0; array_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        n_vec++;
        if ({busy, res_valid, err, arr_clr, rd_en, row_done} !== '0 ||
            activations !== '0 || weights !== '0 || dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state busy=%b rv=%b err=%b clr=%b rd_en=%h rdone=%h st=%0d exp=all zero",
                     busy, res_valid, err, arr_clr, rd_en, row_done, dbg_state);
        end
    endtask

    task automatic test_start_without_en();
        @(negedge clk); start = 1'b1; en = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0; en = 1'b1; #1;
        n_vec++; if (busy !== 1'b0 || arr_clr !== 1'b0) begin
            n_err++; $display("FAIL start_no_en busy=%b arr_clr=%b exp=0,0", busy, arr_clr);
        end
    endtask

    task automatic test_nominal();
        int rv0, clr0;
        fill_pattern();
        rv0 = rv_cnt; clr0 = clr_cnt;
        run_tile(-1, 0, 1'b0, 5, -1, 1'b0);
        n_vec++; if (rv_cnt - rv0 !== 1) begin n_err++; $display("FAIL nominal_rv_count got=%0d exp=1", rv_cnt - rv0); end
        n_vec++; if (clr_cnt - clr0 !== 1) begin n_err++; $display("FAIL nominal_clr_count got=%0d exp=1", clr_cnt - clr0); end
    endtask

    task automatic test_stall();
        fill_pattern();
        run_tile(5, 3, 1'b0, 5, -1, 1'b0);
    endtask

    task automatic test_timeout();
        int rv0;
        fill_random();
        rv0 = rv_cnt;
        run_tile(-1, 0, 1'b0, -1, -1, 1'b0);
        n_vec++; if (rv_cnt - rv0 !== 0) begin n_err++; $display("FAIL timeout_rv_count got=%0d exp=0", rv_cnt - rv0); end
        // the following tile checks err==0 right after its start is accepted
        fill_random();
        run_tile(-1, 0, 1'b0, 3, -1, 1'b0);
    endtask

    task automatic test_simultaneous();
        fill_random();
        run_tile(-1, 0, 1'b0, TMO - 1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_feed();
        fill_pattern();
        run_tile(-1, 0, 1'b0, 0, 7, 1'b0);
        run_tile(-1, 0, 1'b0, 5, -1, 1'b0);
    endtask

    task automatic test_start_in_wait();
        int rv0, clr0;
        fill_random();
        rv0 = rv_cnt; clr0 = clr_cnt;
        run_tile(-1, 0, 1'b0, 6, -1, 1'b1);
        n_vec++; if (rv_cnt - rv0 !== 1) begin n_err++; $display("FAIL poke_rv_count got=%0d exp=1", rv_cnt - rv0); end
        n_vec++; if (clr_cnt - clr0 !== 1) begin n_err++; $display("FAIL poke_clr_count got=%0d exp=1", clr_cnt - clr0); end
    endtask

    task automatic test_back_to_back_random();
        int rv0, clr0, exp_rv, d;
        rv0 = rv_cnt; clr0 = clr_cnt; exp_rv = 0;
        for (int i = 0; i < 8; i++) begin
            fill_random();
            d = $urandom_range(0, TMO + 2);
            if (d >= TMO) d = -1;
            else exp_rv++;
            run_tile(-1, 0, 1'b1, d, -1, 1'($urandom_range(0, 1)));
        end
        n_vec++; if (rv_cnt - rv0 !== exp_rv) begin n_err++; $display("FAIL random_rv_count got=%0d exp=%0d", rv_cnt - rv0, exp_rv); end
        n_vec++; if (clr_cnt - clr0 !== 8) begin n_err++; $display("FAIL random_clr_count got=%0d exp=8", clr_cnt - clr0); end
    endtask

    initial begin
        n_vec = 0; n_err = 0; rv_cnt = 0; clr_cnt = 0;
        rst = 1'b1; en = 1'b0; start = 1'b0; array_done = 1'b0;
        act_rdata = '0; wgt_rdata = '0;
        fill_pattern();
        test_reset();
        test_start_without_en();
        test_nominal();
        test_stall();
        test_timeout();
        test_simultaneous();
        test_reset_mid_feed();
        test_start_in_wait();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
